// File: rtl/demux_pkg.sv
// Shared types and constants for the demux_stream channel router.
// Used by demux_slot and demux_stream.
package demux_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] sel_t;
    typedef logic [7:0] count_t;

    // Increment that sticks at the top of the range instead of wrapping.
    function automatic count_t sat_inc(input count_t c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// A load and a pop in the same cycle keep the slot full (no bubble).
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Space for a new word exists when empty or when the current word leaves this cycle.
    assign ready_o = !valid_q || pop_ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && pop_ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_stream.sv
// Routes a valid/ready input stream into one of four holding registers.
// Optional macro DEMUX_RR_EN: destination chosen by a round-robin pointer instead of select.
//
// Handshake: a word moves whenever valid and ready are both high on a rising clk edge;
// the producer holds valid and data stable until that happens.
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       xfer_count
);

    sel_t             sel_eff;
    logic             xfer;
    logic [NCH-1:0]   slot_load;
    logic [NCH-1:0]   slot_ready;
    logic [WIDTH-1:0] slot_data [NCH];
    count_t           count_q, count_d;

`ifdef DEMUX_RR_EN
    sel_t ptr_q, ptr_d;

    assign sel_eff = ptr_q;

    // Pointer only moves on an accepted word, so a stalled channel holds it in place.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign sel_eff = select;
`endif

    assign in_ready = slot_ready[sel_eff];
    assign xfer     = in_valid && in_ready;

    always_comb begin
        slot_load = '0;
        if (xfer) begin
            slot_load[sel_eff] = 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk_i       (clk),
            .rst_i       (rst),
            .load_i      (slot_load[i]),
            .data_i      (in_data),
            .pop_ready_i (out_ready[i]),
            .data_o      (slot_data[i]),
            .valid_o     (out_valid[i]),
            .ready_o     (slot_ready[i])
        );
    end

    always_comb begin
        count_d = count_q;
        if (xfer) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out0       = slot_data[0];
    assign out1       = slot_data[1];
    assign out2       = slot_data[2];
    assign out3       = slot_data[3];
    assign xfer_count = count_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: vector table plus hand-written reset,
// round-robin (DEMUX_RR_EN) and saturation sequences.
module tb_demux_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] select = '0;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready = '0;
    logic [7:0] xfer_count;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
        logic       vld;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        int         chk;
        logic [3:0] exp_out;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [15];

    demux_stream #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] get_out(input int ch);
        case (ch)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check in_ready before the edge and state after it.
    task automatic apply(input string tag, input logic [1:0] sel, input logic [3:0] data,
                         input logic vld, input logic [3:0] ordy, input logic exp_rdy,
                         input logic [3:0] exp_ov, input int chk, input logic [3:0] exp_out,
                         input logic [7:0] exp_cnt);
        @(negedge clk);
        select    = sel;
        in_data   = data;
        in_valid  = vld;
        out_ready = ordy;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(exp_ov));
        check($sformatf("%s out%0d", tag, chk), 32'(get_out(chk)), 32'(exp_out));
        check({tag, " xfer_count"}, 32'(xfer_count), 32'(exp_cnt));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Reset state while rst is high, before any clock edge.
        #1;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset out0", 32'(out0), 32'h0);
        check("reset out3", 32'(out3), 32'h0);
        check("reset xfer_count", 32'(xfer_count), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;

`ifndef DEMUX_RR_EN
        //          sel   data   vld   ordy     rdy   ov       ch out    cnt
        vecs[0]  = '{2'd0, 4'hC, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 4'hC, 8'd1};
        vecs[1]  = '{2'd1, 4'hD, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 4'hD, 8'd2};
        vecs[2]  = '{2'd2, 4'hE, 1'b1, 4'b1111, 1'b1, 4'b0100, 2, 4'hE, 8'd3};
        vecs[3]  = '{2'd3, 4'hF, 1'b1, 4'b1111, 1'b1, 4'b1000, 3, 4'hF, 8'd4};
        vecs[4]  = '{2'd0, 4'h0, 1'b0, 4'b1111, 1'b1, 4'b0000, 3, 4'hF, 8'd4};
        vecs[5]  = '{2'd2, 4'hA, 1'b1, 4'b0000, 1'b1, 4'b0100, 2, 4'hA, 8'd5};
        vecs[6]  = '{2'd2, 4'h5, 1'b1, 4'b0000, 1'b0, 4'b0100, 2, 4'hA, 8'd5};
        vecs[7]  = '{2'd2, 4'h5, 1'b1, 4'b0100, 1'b1, 4'b0100, 2, 4'h5, 8'd6};
        vecs[8]  = '{2'd1, 4'h7, 1'b1, 4'b0000, 1'b1, 4'b0110, 1, 4'h7, 8'd7};
        vecs[9]  = '{2'd1, 4'h9, 1'b1, 4'b0000, 1'b0, 4'b0110, 1, 4'h7, 8'd7};
        vecs[10] = '{2'd3, 4'h3, 1'b1, 4'b0000, 1'b1, 4'b1110, 3, 4'h3, 8'd8};
        vecs[11] = '{2'd0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'b1110, 1, 4'h7, 8'd8};
        vecs[12] = '{2'd0, 4'h6, 1'b1, 4'b1110, 1'b1, 4'b0001, 0, 4'h6, 8'd9};
        vecs[13] = '{2'd0, 4'h8, 1'b1, 4'b0001, 1'b1, 4'b0001, 0, 4'h8, 8'd10};
        vecs[14] = '{2'd0, 4'hB, 1'b1, 4'b0000, 1'b0, 4'b0001, 0, 4'h8, 8'd10};
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].vld,
                  vecs[i].ordy, vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].chk,
                  vecs[i].exp_out, vecs[i].exp_cnt);
        end
`else
        // Round robin with select pinned at 3; words land 0,1,2,3 then wrap to 0.
        apply("rr1", 2'd3, 4'h1, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 4'h1, 8'd1);
        apply("rr2", 2'd3, 4'h2, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 4'h2, 8'd2);
        apply("rr3", 2'd3, 4'h3, 1'b1, 4'b1111, 1'b1, 4'b0100, 2, 4'h3, 8'd3);
        apply("rr4", 2'd3, 4'h4, 1'b1, 4'b1111, 1'b1, 4'b1000, 3, 4'h4, 8'd4);
        apply("rr5", 2'd3, 4'h5, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 4'h5, 8'd5);
        apply("rr6", 2'd3, 4'h6, 1'b1, 4'b0000, 1'b1, 4'b0011, 1, 4'h6, 8'd6);
        apply("rr7", 2'd3, 4'h7, 1'b1, 4'b0000, 1'b1, 4'b0111, 2, 4'h7, 8'd7);
        apply("rr8", 2'd3, 4'h8, 1'b1, 4'b0000, 1'b1, 4'b1111, 3, 4'h8, 8'd8);
        apply("rr9a", 2'd3, 4'h9, 1'b1, 4'b0000, 1'b0, 4'b1111, 0, 4'h5, 8'd8);
        apply("rr9b", 2'd3, 4'h9, 1'b1, 4'b0000, 1'b0, 4'b1111, 0, 4'h5, 8'd8);
        apply("rr9c", 2'd3, 4'h9, 1'b1, 4'b0001, 1'b1, 4'b1111, 0, 4'h9, 8'd9);
        apply("rr10", 2'd3, 4'hA, 1'b1, 4'b0000, 1'b0, 4'b1111, 1, 4'h6, 8'd9);
`endif

        // Asynchronous reset between edges while channels hold data.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("async out_valid", 32'(out_valid), 32'h0);
        check("async out0", 32'(out0), 32'h0);
        check("async out1", 32'(out1), 32'h0);
        check("async out2", 32'(out2), 32'h0);
        check("async out3", 32'(out3), 32'h0);
        check("async xfer_count", 32'(xfer_count), 32'h0);
        check("async in_ready", 32'(in_ready), 32'h1);
        // A word offered across an edge with rst high is dropped.
        select   = 2'd0;
        in_data  = 4'hA;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst-edge out_valid", 32'(out_valid), 32'h0);
        check("rst-edge out0", 32'(out0), 32'h0);
        rst = 1'b0;
        apply("post-rst", 2'd0, 4'h4, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 4'h4, 8'd1);

        // Saturation: 254 transfers, then 46 more.
        in_valid = 1'b0;
        pulse_reset();
        @(negedge clk);
        select    = 2'd0;
        in_data   = 4'h1;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        repeat (254) @(posedge clk);
        #1;
        check("count 254", 32'(xfer_count), 32'd254);
        repeat (46) @(posedge clk);
        #1;
        check("count saturated", 32'(xfer_count), 32'd255);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
